// File: rtl/decred_spi_pkg.sv
// rtl/decred_spi_pkg.sv - shared constants and FSM state type for the decred SPI slave
package decred_spi_pkg;

    localparam int ADDR_W_DEFAULT = 7;
    localparam int CMD_RW_BIT     = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } spi_state_t;

endpackage

// File: rtl/decred_spi_sync.sv
// rtl/decred_spi_sync.sv - pin synchroniser with rise/fall pulses taken from the last stage
module decred_spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/decred_spi_slave.sv
// rtl/decred_spi_slave.sv - SPI mode-0 slave to register bus; SPI_ADDR_AUTOINC_EN enables address auto-increment
module decred_spi_slave
    import decred_spi_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic              SPI_CLK,
    input  logic              SPI_CLK_RESET_N,
    input  logic              SCLK_fromHost,
    input  logic              SCSN_fromHost,
    input  logic              MOSI_fromHost,
    output logic              MISO_toHost,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy
);

    logic [1:0]  rst_q;
    logic        rst_n_i;
    logic        sclk_level, sclk_rise, sclk_fall;
    logic        scsn_level, scsn_rise, scsn_fall;
    logic        mosi_s, mosi_rise, mosi_fall;
    logic        unused_ok;
    spi_state_t  state_q, state_d;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_shift;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_shift;
    logic        byte_done;
    logic [ADDR_W-1:0] next_addr;

    // Reset asserts asynchronously but is released on an SPI_CLK edge
    always_ff @(posedge SPI_CLK or negedge SPI_CLK_RESET_N) begin
        if (!SPI_CLK_RESET_N) rst_q <= 2'b00;
        else                  rst_q <= {rst_q[0], 1'b1};
    end
    assign rst_n_i = rst_q[1];

    decred_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(SPI_CLK), .rst_n(rst_n_i), .din(SCLK_fromHost),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );
    decred_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_scsn (
        .clk(SPI_CLK), .rst_n(rst_n_i), .din(SCSN_fromHost),
        .level(scsn_level), .rise(scsn_rise), .fall(scsn_fall)
    );
    decred_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(SPI_CLK), .rst_n(rst_n_i), .din(MOSI_fromHost),
        .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );
    assign unused_ok = &{1'b0, sclk_level, scsn_level, mosi_rise, mosi_fall};

    assign rx_byte   = {rx_shift, mosi_s};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7) && (state_q != IDLE);

`ifdef SPI_ADDR_AUTOINC_EN
    assign next_addr = reg_addr + ADDR_W'(1);
`else
    assign next_addr = reg_addr;
`endif

    always_ff @(posedge SPI_CLK or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (scsn_fall) state_d = CMD;
            CMD:     if (byte_done) state_d = rx_byte[CMD_RW_BIT] ? RDATA : WDATA;
            default: state_d = state_q;
        endcase
        // A byte completing together with deselect is still acted on by the datapath
        if (scsn_rise && (state_q != IDLE)) state_d = IDLE;
    end

    always_ff @(posedge SPI_CLK or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bit_cnt   <= 3'd0;
            rx_shift  <= 7'd0;
            tx_shift  <= 8'd0;
            reg_addr  <= '0;
            reg_wdata <= 8'd0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            if (reg_we) reg_addr <= next_addr;
            if (state_q == IDLE) begin
                if (scsn_fall) begin
                    bit_cnt  <= 3'd0;
                    rx_shift <= 7'd0;
                    tx_shift <= 8'd0;
                end
            end else begin
                if (sclk_rise) begin
                    bit_cnt  <= bit_cnt + 3'd1;
                    rx_shift <= rx_byte[6:0];
                end
                // Holding at count 0 keeps a freshly loaded MSB across the byte boundary
                if (sclk_fall && (state_q == RDATA) && (bit_cnt != 3'd0))
                    tx_shift <= {tx_shift[6:0], 1'b0};
                if (byte_done) begin
                    case (state_q)
                        CMD: begin
                            reg_addr <= ADDR_W'(rx_byte[CMD_RW_BIT-1:0]);
                            reg_re   <= rx_byte[CMD_RW_BIT];
                        end
                        WDATA: begin
                            reg_wdata <= rx_byte;
                            reg_we    <= 1'b1;
                        end
                        RDATA: begin
                            reg_addr <= next_addr;
                            reg_re   <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            if (reg_re) tx_shift <= reg_rdata;
        end
    end

    assign MISO_toHost = (state_q == RDATA) ? tx_shift[7] : 1'b0;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_decred_spi_slave.sv
// tb/tb_decred_spi_slave.sv - self-checking bench for decred_spi_slave (honours SPI_ADDR_AUTOINC_EN)
`timescale 1ns/1ps
module tb_decred_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       scsn = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;

    int tests_run = 0;
    int tests_failed = 0;

    decred_spi_slave dut (
        .SPI_CLK(clk), .SPI_CLK_RESET_N(rst_n),
        .SCLK_fromHost(sclk), .SCSN_fromHost(scsn), .MOSI_fromHost(mosi),
        .MISO_toHost(miso), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Register file seen by the DUT, plus the spec-level expectation of its contents
    logic [7:0]  seed_mem  [0:127];
    logic [7:0]  mem       [0:127];
    logic [7:0]  model_mem [0:127];
    logic        mem_ready = 1'b0;
    logic [14:0] we_q [$];
    logic [6:0]  re_q [$];
    int          miso_hi = 0;
    logic        watch_miso = 1'b0;

    assign reg_rdata = mem[reg_addr];

    always @(negedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 128; i++) mem[i] <= seed_mem[i];
            mem_ready <= 1'b1;
        end else if (reg_we) begin
            mem[reg_addr] <= reg_wdata;
        end
        if (reg_we) we_q.push_back({reg_addr, reg_wdata});
        if (reg_re) re_q.push_back(reg_addr);
        if (watch_miso && miso) miso_hi <= miso_hi + 1;
    end

    logic [7:0] tx_buf [0:79];
    logic [7:0] rx_buf [0:79];
    int hi_ns = 40;
    int lo_ns = 40;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic align(input int phase);
        @(posedge clk);
        #(phase);
    endtask

    // Mode-0 host: MOSI changes on the falling edge, MISO sampled on the rising edge
    task automatic spi_xfer(input int nbytes, input int extra_bits, input bit end_cs);
        int total;
        int b;
        int k;
        total = nbytes * 8 + extra_bits;
        scsn = 1'b0;
        #(hi_ns + lo_ns);
        for (int n = 0; n < total; n++) begin
            b = n / 8;
            k = 7 - (n % 8);
            mosi = tx_buf[b][k];
            #(lo_ns);
            sclk = 1'b1;
            rx_buf[b][k] = miso;
            #(hi_ns);
            sclk = 1'b0;
        end
        #(lo_ns);
        if (end_cs) begin
            scsn = 1'b1;
            #(2 * (hi_ns + lo_ns));
        end
    endtask

    function automatic logic [6:0] exp_addr(input logic [6:0] base, input int i);
`ifdef SPI_ADDR_AUTOINC_EN
        return base + 7'(i);
`else
        return base;
`endif
    endfunction

    function automatic logic [14:0] we_at(input int i);
        if (i < we_q.size()) return we_q[i];
        return 15'h7fff;
    endfunction

    function automatic logic [6:0] re_at(input int i);
        if (i < re_q.size()) return re_q[i];
        return 7'h7f;
    endfunction

    int         we0;
    int         re0;
    int         mh0;
    logic [6:0] base;
    logic [7:0] lb_data [0:63];

    initial begin
        for (int i = 0; i < 128; i++) begin
            seed_mem[i] = 8'($urandom);
        end
        seed_mem[5] = 8'h3C;
        seed_mem[6] = 8'hC3;
        for (int i = 0; i < 128; i++) model_mem[i] = seed_mem[i];

        // Reset values
        repeat (4) @(posedge clk);
        #1;
        check("rst_miso", miso, 0);
        check("rst_we", reg_we, 0);
        check("rst_re", reg_re, 0);
        check("rst_addr", reg_addr, 0);
        check("rst_wdata", reg_wdata, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Read burst at 8x: command 0x85 then two data bytes
        we0 = we_q.size();
        re0 = re_q.size();
        tx_buf[0] = 8'h85; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
        align(3);
        spi_xfer(3, 0, 1);
        check("rd_cmd_miso", rx_buf[0], 8'h00);
        check("rd_byte0", rx_buf[1], model_mem[exp_addr(7'h05, 0)]);
        check("rd_byte1", rx_buf[2], model_mem[exp_addr(7'h05, 1)]);
        check("rd_re_addr0", re_at(re0), 7'h05);
        check("rd_re_addr1", re_at(re0 + 1), exp_addr(7'h05, 1));
        check("rd_no_write", we_q.size() - we0, 0);
        check("rd_busy_end", busy, 0);

        // Write 0x05 <- 0xA5; MISO must stay low
        we0 = we_q.size();
        mh0 = miso_hi;
        watch_miso = 1'b1;
        tx_buf[0] = 8'h05; tx_buf[1] = 8'hA5;
        align(3);
        spi_xfer(2, 0, 1);
        watch_miso = 1'b0;
        model_mem[5] = 8'hA5;
        check("wr_count", we_q.size() - we0, 1);
        check("wr_event", we_at(we0), {7'h05, 8'hA5});
        check("wr_miso_low", miso_hi - mh0, 0);
        check("wr_busy_end", busy, 0);

        // Address wrap at 0x7F
        we0 = we_q.size();
        tx_buf[0] = 8'h7F; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22;
        align(3);
        spi_xfer(3, 0, 1);
        model_mem[exp_addr(7'h7F, 0)] = 8'h11;
        model_mem[exp_addr(7'h7F, 1)] = 8'h22;
        check("wrap_count", we_q.size() - we0, 2);
        check("wrap_event0", we_at(we0), {exp_addr(7'h7F, 0), 8'h11});
        check("wrap_event1", we_at(we0 + 1), {exp_addr(7'h7F, 1), 8'h22});

        // Deselect after 4 data bits discards the partial byte
        we0 = we_q.size();
        tx_buf[0] = 8'h05; tx_buf[1] = 8'hFF;
        align(3);
        spi_xfer(1, 4, 0);
        check("abort_busy_active", busy, 1);
        scsn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("abort_busy_end", busy, 0);
        check("abort_no_write", we_q.size() - we0, 0);

        // Reset pulse during the 3rd data bit, SCSN still low at release
        we0 = we_q.size();
        tx_buf[0] = 8'h20; tx_buf[1] = 8'h5A;
        align(3);
        spi_xfer(1, 2, 0);
        mosi = tx_buf[1][5];
        #(lo_ns);
        sclk = 1'b1;
        #(hi_ns / 2);
        check("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", reg_addr, 0);
        check("mid_rst_outs", {miso, reg_we, reg_re, reg_wdata}, 0);
        #(hi_ns / 2);
        sclk = 1'b0;
        #(lo_ns);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("mid_no_start", busy, 0);
        scsn = 1'b1;
        repeat (10) @(posedge clk);
        tx_buf[0] = 8'h10; tx_buf[1] = 8'h99;
        align(3);
        spi_xfer(2, 0, 1);
        model_mem[8'h10] = 8'h99;
        check("mid_clean_count", we_q.size() - we0, 1);
        check("mid_clean_event", we_at(we0), {7'h10, 8'h99});

        // 4x loopback with random phase and a 25% high SCLK duty
        hi_ns = 10;
        lo_ns = 30;
        base = 7'($urandom_range(0, 127));
        we0 = we_q.size();
        mh0 = miso_hi;
        tx_buf[0] = {1'b0, base};
        for (int i = 0; i < 64; i++) begin
            lb_data[i] = 8'($urandom);
            tx_buf[i + 1] = lb_data[i];
        end
        watch_miso = 1'b1;
        align($urandom_range(1, 9));
        spi_xfer(65, 0, 1);
        watch_miso = 1'b0;
        for (int i = 0; i < 64; i++) model_mem[exp_addr(base, i)] = lb_data[i];
        check("lb_wr_count", we_q.size() - we0, 64);
        check("lb_wr_miso_low", miso_hi - mh0, 0);
        for (int i = 0; i < 64; i++) check($sformatf("lb_wr%0d", i), we_at(we0 + i), {exp_addr(base, i), lb_data[i]});
        tx_buf[0] = {1'b1, base};
        for (int i = 1; i <= 64; i++) tx_buf[i] = 8'($urandom);
        align($urandom_range(1, 9));
        spi_xfer(65, 0, 1);
        for (int i = 0; i < 64; i++) check($sformatf("lb_rd%0d", i), rx_buf[i + 1], model_mem[exp_addr(base, i)]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
